if_fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the program counter and drives instruction-memory requests through a req/ready handshake.
- Applies hazard stalls and branch/jump redirects from ID.
- Produces the PC+4 / instruction / flush / enable signals that the IF/ID register captures every cycle.

---
 rtl/if_fetch_unit_pkg.sv | 14 +
 rtl/if_next_pc.sv | 21 ++
 rtl/if_fetch_unit.sv | 116 +++++++++++
 tb/tb_if_fetch_unit.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared constants and FSM encoding for the instruction-fetch stage.
package if_fetch_unit_pkg;

    localparam int                WORD_W       = 32;
    localparam logic [WORD_W-1:0] PC_RESET_DEF = 32'h0000_0000;
    localparam int                PC_STEP_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_next_pc.sv
// Combinational next-PC helper: redirect target select and sequential PC adder.
module if_next_pc
    import if_fetch_unit_pkg::*;
#(
    parameter int PC_STEP = PC_STEP_DEF
) (
    input  logic              branch,
    input  logic [WORD_W-1:0] branch_target,
    input  logic [WORD_W-1:0] jump_target,
    input  logic [WORD_W-1:0] req_addr,
    output logic [WORD_W-1:0] target,
    output logic [WORD_W-1:0] seq_addr
);

    localparam logic [WORD_W-1:0] STEP = WORD_W'(PC_STEP);

    // Branch takes priority when ID resolves both in the same cycle.
    assign target   = branch ? branch_target : jump_target;
    assign seq_addr = req_addr + STEP;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, imem req/ready handshake, stall and redirect handling.
// Optional FETCH_PERF_CNT_EN adds fetch / memory-stall cycle counters.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [WORD_W-1:0] PC_RESET = PC_RESET_DEF,
    parameter int                PC_STEP  = PC_STEP_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              hz_i,
    input  logic              branch_i,
    input  logic [WORD_W-1:0] branch_target_i,
    input  logic              jump_i,
    input  logic [WORD_W-1:0] jump_target_i,
    output logic              imem_req_o,
    output logic [WORD_W-1:0] imem_addr_o,
    input  logic              imem_ready_i,
    input  logic [WORD_W-1:0] imem_data_i,
    output logic [WORD_W-1:0] pc_o,
    output logic [WORD_W-1:0] inst_o,
    output logic              flush_o,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]       fetch_cnt_o,
    output logic [31:0]       stall_cnt_o,
`endif
    output logic              pc_enable_o
);

    fetch_state_t      state;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] req_addr;

    fetch_state_t      cur_state;
    logic [WORD_W-1:0] cur_addr;
    logic [WORD_W-1:0] target;
    logic [WORD_W-1:0] seq_addr;
    logic              redir;
    logic              valid;

    // While reset is held, present the reset state rather than stale registers.
    assign cur_state = rst_i ? state    : IDLE;
    assign cur_addr  = rst_i ? req_addr : PC_RESET;

    if_next_pc #(.PC_STEP(PC_STEP)) u_next_pc (
        .branch        (branch_i),
        .branch_target (branch_target_i),
        .jump_target   (jump_target_i),
        .req_addr      (cur_addr),
        .target        (target),
        .seq_addr      (seq_addr)
    );

    // A stalled ID re-presents its redirect next cycle, so it is dropped here.
    assign redir = (branch_i | jump_i) & ~hz_i;
    assign valid = (cur_state == REQ) & imem_ready_i;

    assign imem_req_o  = (cur_state != IDLE);
    assign imem_addr_o = cur_addr;
    assign inst_o      = imem_data_i;
    assign pc_o        = seq_addr;
    assign pc_enable_o = valid & ~hz_i & ~redir;
    assign flush_o     = ~hz_i & (redir | ~valid);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            pc       <= PC_RESET;
            req_addr <= PC_RESET;
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (imem_ready_i) begin
                        if (redir) begin
                            pc       <= target;
                            req_addr <= target;
                        end else if (!hz_i) begin
                            pc       <= seq_addr;
                            req_addr <= seq_addr;
                        end
                    end else if (redir) begin
                        pc    <= target;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The wrong-path response is dropped whatever hz_i says;
                    // a redirect landing on the same cycle is fetched directly.
                    if (imem_ready_i) begin
                        req_addr <= redir ? target : pc;
                        state    <= REQ;
                    end
                    if (redir)
                        pc <= target;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            fetch_cnt_o <= '0;
            stall_cnt_o <= '0;
        end else begin
            if (pc_enable_o)
                fetch_cnt_o <= fetch_cnt_o + 32'd1;
            if (imem_req_o && !imem_ready_i)
                stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit (sequential fetch, stalls, redirects, reset).
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        hz = 1'b0;
    logic        br = 1'b0;
    logic [31:0] br_tgt = '0;
    logic        jp = 1'b0;
    logic [31:0] jp_tgt = '0;
    logic        req;
    logic [31:0] addr;
    logic        rdy = 1'b1;
    logic [31:0] data = '0;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        flush;
    logic        en;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .hz_i            (hz),
        .branch_i        (br),
        .branch_target_i (br_tgt),
        .jump_i          (jp),
        .jump_target_i   (jp_tgt),
        .imem_req_o      (req),
        .imem_addr_o     (addr),
        .imem_ready_i    (rdy),
        .imem_data_i     (data),
        .pc_o            (pc),
        .inst_o          (inst),
        .flush_o         (flush),
`ifdef FETCH_PERF_CNT_EN
        .fetch_cnt_o     (fetch_cnt),
        .stall_cnt_o     (stall_cnt),
`endif
        .pc_enable_o     (en)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks req / addr / flush / enable after inputs settle.
    task automatic chk_out(input string tag, input logic e_req, input logic [31:0] e_addr,
                           input logic e_flush, input logic e_en);
        #1;
        chk({tag, ".req"},   {31'd0, req},   {31'd0, e_req});
        chk({tag, ".addr"},  addr,           e_addr);
        chk({tag, ".flush"}, {31'd0, flush}, {31'd0, e_flush});
        chk({tag, ".en"},    {31'd0, en},    {31'd0, e_en});
    endtask

    initial begin
        data = 32'hDEAD_BEEF;
        tick();
        rst = 1'b1;

        chk_out("idle", 1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        chk_out("f0", 1'b1, 32'h0, 1'b0, 1'b1);
        chk("f0.pc", pc, 32'h4);
        chk("f0.inst", inst, 32'hDEAD_BEEF);
        tick();
        chk_out("f4", 1'b1, 32'h4, 1'b0, 1'b1);
        chk("f4.pc", pc, 32'h8);
        tick();

        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_out("wait8", 1'b1, 32'h8, 1'b1, 1'b0);
            tick();
        end
        rdy = 1'b1;
        chk_out("f8", 1'b1, 32'h8, 1'b0, 1'b1);
        chk("f8.pc", pc, 32'hC);
        tick();
        chk_out("fC", 1'b1, 32'hC, 1'b0, 1'b1);
        tick();

        hz = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk_out("hz10", 1'b1, 32'h10, 1'b0, 1'b0);
            tick();
        end
        hz = 1'b0;
        chk_out("f10", 1'b1, 32'h10, 1'b0, 1'b1);
        tick();
        chk_out("f14", 1'b1, 32'h14, 1'b0, 1'b1);
        tick();

        br = 1'b1; br_tgt = 32'h100; jp = 1'b1; jp_tgt = 32'h200;
        chk_out("brjp", 1'b1, 32'h18, 1'b1, 1'b0);
        tick();
        br = 1'b0; jp = 1'b0;
        chk_out("f100", 1'b1, 32'h100, 1'b0, 1'b1);
        chk("f100.pc", pc, 32'h104);
        tick();

        jp = 1'b1; jp_tgt = 32'h20;
        chk_out("jp20", 1'b1, 32'h104, 1'b1, 1'b0);
        tick();
        rdy = 1'b0; jp_tgt = 32'h40;
        chk_out("redir_pend", 1'b1, 32'h20, 1'b1, 1'b0);
        tick();
        jp = 1'b0;
        chk_out("drain_wait", 1'b1, 32'h20, 1'b1, 1'b0);
        tick();
        rdy = 1'b1;
        chk_out("drain_done", 1'b1, 32'h20, 1'b1, 1'b0);
        tick();
        chk_out("f40", 1'b1, 32'h40, 1'b0, 1'b1);
        tick();

        // Redirect under hazard is ignored; the stall dominates.
        hz = 1'b1; br = 1'b1; br_tgt = 32'h80;
        chk_out("hz_br", 1'b1, 32'h44, 1'b0, 1'b0);
        tick();
        hz = 1'b0; br = 1'b0;
        chk_out("f44", 1'b1, 32'h44, 1'b0, 1'b1);
        tick();

        rdy = 1'b0; jp = 1'b1; jp_tgt = 32'h60;
        chk_out("redir48", 1'b1, 32'h48, 1'b1, 1'b0);
        tick();
        jp = 1'b0;
        chk_out("drain48", 1'b1, 32'h48, 1'b1, 1'b0);
`ifdef FETCH_PERF_CNT_EN
        chk("cnt.fetch", fetch_cnt, 32'd9);
        chk("cnt.stall", stall_cnt, 32'd6);
`endif
        rst = 1'b0;
        chk_out("in_rst", 1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        rst = 1'b1;
        chk_out("post_rst", 1'b0, 32'h0, 1'b1, 1'b0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst.fetch", fetch_cnt, 32'd0);
        chk("rst.stall", stall_cnt, 32'd0);
`endif
        rdy = 1'b1;
        tick();
        chk_out("refetch0", 1'b1, 32'h0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
